// File: rtl/noc_network_interface_if.sv
// noc_network_interface_if: client inject, router local-port and client eject signals of one NI,
// plus sticky error flags and statistics counters.
// master = the network interface itself, slave = client/router side.
interface noc_network_interface_if #(
  parameter int DATA_W       = 8,
  parameter int NODE_PER_ROW = 4,
  parameter int NODE_PER_COL = 4
);
  localparam int X_W       = (NODE_PER_ROW > 1) ? $clog2(NODE_PER_ROW) : 1;
  localparam int Y_W       = (NODE_PER_COL > 1) ? $clog2(NODE_PER_COL) : 1;
  localparam int PAYLOAD_W = DATA_W - X_W - Y_W;

  // client inject side
  logic                 src_valid;
  logic                 src_ready;
  logic [X_W-1:0]       src_dst_dim0;
  logic [Y_W-1:0]       src_dst_dim1;
  logic [PAYLOAD_W-1:0] src_payload;
  // router local port
  logic                 noc_valid_o;
  logic [DATA_W-1:0]    noc_data_o;
  logic                 noc_off_i;
  logic                 noc_valid_i;
  logic [DATA_W-1:0]    noc_data_i;
  logic                 noc_off_o;
  // client eject side
  logic                 snk_valid;
  logic                 snk_ready;
  logic [PAYLOAD_W-1:0] snk_payload;
  logic                 snk_dst_ok;
  // status
  logic                 err_overflow;
  logic                 err_misroute;
  logic [15:0]          stat_inj;
  logic [15:0]          stat_ej;
  logic [15:0]          stat_stall;

  modport master (
    input  src_valid, src_dst_dim0, src_dst_dim1, src_payload,
           noc_off_i, noc_valid_i, noc_data_i, snk_ready,
    output src_ready, noc_valid_o, noc_data_o, noc_off_o,
           snk_valid, snk_payload, snk_dst_ok,
           err_overflow, err_misroute, stat_inj, stat_ej, stat_stall
  );

  modport slave (
    output src_valid, src_dst_dim0, src_dst_dim1, src_payload,
           noc_off_i, noc_valid_i, noc_data_i, snk_ready,
    input  src_ready, noc_valid_o, noc_data_o, noc_off_o,
           snk_valid, snk_payload, snk_dst_ok,
           err_overflow, err_misroute, stat_inj, stat_ej, stat_stall
  );
endinterface

// File: rtl/noc_network_interface.sv
// noc_network_interface: packs client messages into single flits for the router local port and buffers ejected flits.
// Latency: inject 1 cycle (accept -> noc_valid_o), eject 1 cycle (write -> snk_valid); noc_off_o is registered.
// Backpressure: src_ready from registered inject count; router noc_off_i gates injection; noc_off_o asserted when free entries <= OFF_MARGIN.
// Optional statistics counters are built only when NI_STATS_EN is defined.
module noc_network_interface #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int NODE_PER_ROW = 4,
  parameter int NODE_PER_COL = 4,
  parameter int CURR_DIM0    = 0,
  parameter int CURR_DIM1    = 0,
  parameter int OFF_MARGIN   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  noc_network_interface_if.master bus
);
  localparam int X_W   = (NODE_PER_ROW > 1) ? $clog2(NODE_PER_ROW) : 1;
  localparam int Y_W   = (NODE_PER_COL > 1) ? $clog2(NODE_PER_COL) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(OFF_MARGIN);

  // inject FIFO state
  logic [DATA_W-1:0] r_inj_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_inj_wr, r_inj_rd;
  logic [CNT_W-1:0]  r_inj_cnt;
  // eject FIFO state
  logic [DATA_W-1:0] r_ej_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_ej_wr, r_ej_rd;
  logic [CNT_W-1:0]  r_ej_cnt;
  logic              r_off, r_err_ovf, r_err_mis;

  logic              w_inj_full, w_inj_empty, w_inj_push, w_inj_pop;
  logic              w_ej_full, w_ej_empty, w_ej_wr, w_ej_pop, w_in_mis, w_off_nxt;
  logic [CNT_W-1:0]  w_ej_cnt_nxt;
  logic [DATA_W-1:0] w_src_flit, w_ej_head;

  // Inject side: dst_dim0 occupies the MSBs, then dst_dim1, then payload.
  assign w_src_flit      = {bus.src_dst_dim0, bus.src_dst_dim1, bus.src_payload};
  assign w_inj_full      = (r_inj_cnt == DEPTH_C);
  assign w_inj_empty     = (r_inj_cnt == '0);
  assign bus.src_ready   = !w_inj_full && rst;
  assign w_inj_push      = bus.src_valid && bus.src_ready;
  assign bus.noc_valid_o = !w_inj_empty && !bus.noc_off_i;
  assign w_inj_pop       = bus.noc_valid_o;
  assign bus.noc_data_o  = r_inj_mem[r_inj_rd];

  // Eject side: a write is only lost when full and the client is not popping this cycle.
  assign w_ej_full       = (r_ej_cnt == DEPTH_C);
  assign w_ej_empty      = (r_ej_cnt == '0);
  assign bus.snk_valid   = !w_ej_empty;
  assign w_ej_pop        = bus.snk_valid && bus.snk_ready;
  assign w_ej_wr         = bus.noc_valid_i && (!w_ej_full || w_ej_pop);
  assign w_ej_head       = r_ej_mem[r_ej_rd];
  assign bus.snk_payload = w_ej_head[DATA_W-X_W-Y_W-1:0];
  assign bus.snk_dst_ok  = (w_ej_head[DATA_W-1 -: X_W] == X_W'(CURR_DIM0)) &&
                           (w_ej_head[DATA_W-X_W-1 -: Y_W] == Y_W'(CURR_DIM1));
  assign w_in_mis        = (bus.noc_data_i[DATA_W-1 -: X_W] != X_W'(CURR_DIM0)) ||
                           (bus.noc_data_i[DATA_W-X_W-1 -: Y_W] != Y_W'(CURR_DIM1));
  assign bus.noc_off_o    = r_off;
  assign bus.err_overflow = r_err_ovf;
  assign bus.err_misroute = r_err_mis;

  // Next eject occupancy, including this cycle's write and pop; drives the off decision.
  always_comb begin
    w_ej_cnt_nxt = r_ej_cnt;
    if (w_ej_wr && !w_ej_pop)      w_ej_cnt_nxt = r_ej_cnt + CNT_W'(1);
    else if (!w_ej_wr && w_ej_pop) w_ej_cnt_nxt = r_ej_cnt - CNT_W'(1);
  end
  assign w_off_nxt = (DEPTH_C - w_ej_cnt_nxt) <= MARGIN_C;

  // FIFO storage is data-only and needs no reset; validity comes from the counts.
  always_ff @(posedge clk) begin
    if (w_inj_push) r_inj_mem[r_inj_wr] <= w_src_flit;
    if (w_ej_wr)    r_ej_mem[r_ej_wr]   <= bus.noc_data_i;
  end

  // Inject FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inj_wr  <= '0;
      r_inj_rd  <= '0;
      r_inj_cnt <= '0;
    end else begin
      if (w_inj_push) r_inj_wr <= r_inj_wr + PTR_W'(1);
      if (w_inj_pop)  r_inj_rd <= r_inj_rd + PTR_W'(1);
      case ({w_inj_push, w_inj_pop})
        2'b10:   r_inj_cnt <= r_inj_cnt + CNT_W'(1);
        2'b01:   r_inj_cnt <= r_inj_cnt - CNT_W'(1);
        default: r_inj_cnt <= r_inj_cnt;
      endcase
    end
  end

  // Eject FIFO pointers, occupancy, registered off signal and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ej_wr   <= '0;
      r_ej_rd   <= '0;
      r_ej_cnt  <= '0;
      r_off     <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_mis <= 1'b0;
    end else begin
      if (w_ej_wr)  r_ej_wr <= r_ej_wr + PTR_W'(1);
      if (w_ej_pop) r_ej_rd <= r_ej_rd + PTR_W'(1);
      r_ej_cnt <= w_ej_cnt_nxt;
      r_off    <= w_off_nxt;
      if (bus.noc_valid_i && !w_ej_wr) r_err_ovf <= 1'b1;
      if (w_ej_wr && w_in_mis)         r_err_mis <= 1'b1;
    end
  end

`ifdef NI_STATS_EN
  logic [15:0] r_stat_inj, r_stat_ej, r_stat_stall;
  logic        w_stall;
  assign w_stall = !w_inj_empty && bus.noc_off_i;

  // Saturating event counters: transfers, eject arrivals (dropped included), stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_inj   <= '0;
      r_stat_ej    <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_inj_pop && r_stat_inj != 16'hFFFF)       r_stat_inj   <= r_stat_inj + 16'd1;
      if (bus.noc_valid_i && r_stat_ej != 16'hFFFF)  r_stat_ej    <= r_stat_ej + 16'd1;
      if (w_stall && r_stat_stall != 16'hFFFF)       r_stat_stall <= r_stat_stall + 16'd1;
    end
  end
  assign bus.stat_inj   = r_stat_inj;
  assign bus.stat_ej    = r_stat_ej;
  assign bus.stat_stall = r_stat_stall;
`else
  assign bus.stat_inj   = '0;
  assign bus.stat_ej    = '0;
  assign bus.stat_stall = '0;
`endif
endmodule

// File: tb/tb_noc_network_interface.sv
// tb_noc_network_interface: queue-based reference model of a 4x4-mesh NI at node (1,2);
// directed scenarios plus randomized traffic, each task comparing DUT outputs inline.
// Statistics checks follow whether NI_STATS_EN is defined for the build.
module tb_noc_network_interface;
  localparam int DATA_W = 8, DEPTH = 8, NPR = 4, NPC = 4, CX = 1, CY = 2, MARGIN = 2;
  localparam int X_W = 2, Y_W = 2, PW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_network_interface_if #(.DATA_W(DATA_W), .NODE_PER_ROW(NPR), .NODE_PER_COL(NPC)) bus ();

  noc_network_interface #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .NODE_PER_ROW(NPR), .NODE_PER_COL(NPC),
    .CURR_DIM0(CX), .CURR_DIM1(CY), .OFF_MARGIN(MARGIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int pass_cnt = 0, total_cnt = 0;

  // reference model state
  logic [DATA_W-1:0] inj_q[$];
  logic [DATA_W-1:0] ej_q[$];
  bit m_off, m_ovf, m_mis;
  int m_stat_inj, m_stat_ej, m_stat_stall;
  // expected combinational outputs for the current cycle
  bit exp_src_ready, exp_noc_valid, exp_snk_valid, exp_dst_ok;
  logic [DATA_W-1:0] exp_noc_data;
  logic [PW-1:0] exp_payload;

  function automatic bit own_dst(input logic [DATA_W-1:0] f);
    return (f[DATA_W-1 -: X_W] == X_W'(CX)) && (f[DATA_W-X_W-1 -: Y_W] == Y_W'(CY));
  endfunction

  task automatic model_reset();
    inj_q.delete(); ej_q.delete();
    m_off = 0; m_ovf = 0; m_mis = 0;
    m_stat_inj = 0; m_stat_ej = 0; m_stat_stall = 0;
  endtask

  task automatic model_eval();
    logic [DATA_W-1:0] h;
    exp_src_ready = (inj_q.size() < DEPTH);
    exp_noc_valid = (inj_q.size() != 0) && !bus.noc_off_i;
    exp_noc_data  = (inj_q.size() != 0) ? inj_q[0] : '0;
    exp_snk_valid = (ej_q.size() != 0);
    h = (ej_q.size() != 0) ? ej_q[0] : '0;
    exp_payload = h[PW-1:0];
    exp_dst_ok  = own_dst(h);
  endtask

  // advance one clock: derive this cycle's events from the inputs, then update the model
  task automatic tick();
    bit push, ipop, epop, wr_ok, stall, nvi;
    logic [DATA_W-1:0] sflit, din;
    model_eval();
    push  = bus.src_valid && exp_src_ready;
    ipop  = exp_noc_valid;
    epop  = exp_snk_valid && bus.snk_ready;
    nvi   = bus.noc_valid_i;
    wr_ok = nvi && (ej_q.size() < DEPTH || epop);
    stall = (inj_q.size() != 0) && bus.noc_off_i;
    sflit = {bus.src_dst_dim0, bus.src_dst_dim1, bus.src_payload};
    din   = bus.noc_data_i;
    @(posedge clk);
    if (ipop) void'(inj_q.pop_front());
    if (push) inj_q.push_back(sflit);
    if (epop) void'(ej_q.pop_front());
    if (wr_ok) begin
      ej_q.push_back(din);
      if (!own_dst(din)) m_mis = 1;
    end
    if (nvi && !wr_ok) m_ovf = 1;
    m_off = (DEPTH - ej_q.size()) <= MARGIN;
    if (ipop && m_stat_inj < 65535) m_stat_inj++;
    if (nvi && m_stat_ej < 65535) m_stat_ej++;
    if (stall && m_stat_stall < 65535) m_stat_stall++;
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.src_valid = 0; bus.src_dst_dim0 = '0; bus.src_dst_dim1 = '0; bus.src_payload = '0;
    bus.noc_off_i = 0; bus.noc_valid_i = 0; bus.noc_data_i = '0; bus.snk_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; drive_idle(); model_reset();
    #3;
    total_cnt++; if (bus.noc_valid_o !== 1'b0) $display("FAIL reset_noc_valid: got %b want 0", bus.noc_valid_o); else pass_cnt++;
    total_cnt++; if (bus.noc_off_o !== 1'b0) $display("FAIL reset_noc_off: got %b want 0", bus.noc_off_o); else pass_cnt++;
    total_cnt++; if (bus.src_ready !== 1'b0) $display("FAIL reset_src_ready: got %b want 0", bus.src_ready); else pass_cnt++;
    total_cnt++; if (bus.snk_valid !== 1'b0) $display("FAIL reset_snk_valid: got %b want 0", bus.snk_valid); else pass_cnt++;
    total_cnt++; if ({bus.err_overflow, bus.err_misroute} !== 2'b00) $display("FAIL reset_errors: got %b want 00", {bus.err_overflow, bus.err_misroute}); else pass_cnt++;
    total_cnt++; if ({bus.stat_inj, bus.stat_ej, bus.stat_stall} !== 48'd0) $display("FAIL reset_stats: got %h want 0", {bus.stat_inj, bus.stat_ej, bus.stat_stall}); else pass_cnt++;
    @(negedge clk); rst = 1; #1;
    total_cnt++; if (bus.src_ready !== 1'b1) $display("FAIL reset_release_src_ready: got %b want 1", bus.src_ready); else pass_cnt++;
  endtask

  task automatic test_inject_basic();
    bus.src_valid = 1; bus.src_dst_dim0 = 2'd3; bus.src_dst_dim1 = 2'd0; bus.src_payload = 4'hA; bus.noc_off_i = 0;
    #1;
    total_cnt++; if (bus.noc_valid_o !== 1'b0) $display("FAIL inj_basic_no_early_valid: got %b want 0", bus.noc_valid_o); else pass_cnt++;
    tick();
    bus.src_valid = 0; #1; model_eval();
    total_cnt++; if (bus.noc_valid_o !== 1'b1) $display("FAIL inj_basic_valid: got %b want 1", bus.noc_valid_o); else pass_cnt++;
    total_cnt++; if (bus.noc_data_o !== 8'hCA) $display("FAIL inj_basic_data: got %h want ca", bus.noc_data_o); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (bus.noc_valid_o !== 1'b0) $display("FAIL inj_basic_popped: got %b want 0", bus.noc_valid_o); else pass_cnt++;
`ifdef NI_STATS_EN
    total_cnt++; if (bus.stat_inj !== 16'(m_stat_inj)) $display("FAIL inj_basic_stat_inj: got %0d want %0d", bus.stat_inj, m_stat_inj); else pass_cnt++;
`endif
  endtask

  task automatic test_inject_stall();
    logic [DATA_W-1:0] sent [8];
    bus.noc_off_i = 1;
    for (int i = 0; i < 9; i++) begin
      bus.src_valid = 1; bus.src_dst_dim0 = 2'($urandom); bus.src_dst_dim1 = 2'($urandom); bus.src_payload = 4'(i);
      if (i < 8) sent[i] = {bus.src_dst_dim0, bus.src_dst_dim1, bus.src_payload};
      #1; model_eval();
      total_cnt++; if (bus.src_ready !== (i < 8)) $display("FAIL stall_src_ready_%0d: got %b want %b", i, bus.src_ready, (i < 8)); else pass_cnt++;
      total_cnt++; if (bus.noc_valid_o !== 1'b0) $display("FAIL stall_noc_valid_%0d: got %b want 0", i, bus.noc_valid_o); else pass_cnt++;
`ifdef NI_STATS_EN
      total_cnt++; if (bus.stat_stall !== 16'(m_stat_stall)) $display("FAIL stall_stat_%0d: got %0d want %0d", i, bus.stat_stall, m_stat_stall); else pass_cnt++;
`endif
      tick();
    end
    bus.src_valid = 0; bus.noc_off_i = 0;
    for (int k = 0; k < 8; k++) begin
      #1; model_eval();
      total_cnt++; if (bus.noc_valid_o !== 1'b1 || bus.noc_data_o !== sent[k]) $display("FAIL stall_drain_%0d: got v=%b d=%h want v=1 d=%h", k, bus.noc_valid_o, bus.noc_data_o, sent[k]); else pass_cnt++;
      tick();
    end
    #1;
    total_cnt++; if (bus.noc_valid_o !== 1'b0) $display("FAIL stall_drain_empty: got %b want 0", bus.noc_valid_o); else pass_cnt++;
  endtask

  task automatic test_eject_backpressure();
    bit lag, cur;
    int writes, rise_at;
    lag = 0; writes = 0; rise_at = -1;
    bus.snk_ready = 0;
    for (int c = 0; c < 16; c++) begin
      bus.noc_valid_i = !lag; bus.noc_data_i = {X_W'(CX), Y_W'(CY), 4'(c)};
      #1; model_eval();
      total_cnt++; if (bus.noc_off_o !== m_off) $display("FAIL ej_bp_off_%0d: got %b want %b", c, bus.noc_off_o, m_off); else pass_cnt++;
      if (bus.noc_off_o && rise_at < 0) rise_at = writes;
      cur = bus.noc_off_o;
      if (bus.noc_valid_i) writes++;
      tick();
      lag = cur;
    end
    bus.noc_valid_i = 0; #1;
    total_cnt++; if (rise_at != 6) $display("FAIL ej_bp_rise_point: got %0d want 6", rise_at); else pass_cnt++;
    total_cnt++; if (writes != 7) $display("FAIL ej_bp_writes: got %0d want 7", writes); else pass_cnt++;
    total_cnt++; if (bus.err_overflow !== 1'b0) $display("FAIL ej_bp_overflow: got %b want 0", bus.err_overflow); else pass_cnt++;
    bus.snk_ready = 1;
    for (int d = 0; d < 8; d++) begin
      #1; model_eval();
      total_cnt++; if (bus.snk_valid !== (d < 7) || (d < 7 && bus.snk_payload !== 4'(d))) $display("FAIL ej_bp_drain_%0d: got v=%b p=%h want v=%b p=%h", d, bus.snk_valid, bus.snk_payload, (d < 7), 4'(d)); else pass_cnt++;
      tick();
    end
    #1;
    total_cnt++; if (bus.noc_off_o !== 1'b0) $display("FAIL ej_bp_off_released: got %b want 0", bus.noc_off_o); else pass_cnt++;
    bus.snk_ready = 0;
  endtask

  task automatic test_dst_check();
    bus.snk_ready = 0; bus.noc_valid_i = 1; bus.noc_data_i = 8'h60;
    tick();
    bus.noc_valid_i = 0; #1;
    total_cnt++; if (bus.snk_valid !== 1'b1 || bus.snk_dst_ok !== 1'b1) $display("FAIL dst_ok_own: got v=%b ok=%b want 1 1", bus.snk_valid, bus.snk_dst_ok); else pass_cnt++;
    total_cnt++; if (bus.err_misroute !== 1'b0) $display("FAIL dst_no_misroute: got %b want 0", bus.err_misroute); else pass_cnt++;
    bus.snk_ready = 1; tick();
    bus.snk_ready = 0; bus.noc_valid_i = 1; bus.noc_data_i = 8'h00;
    tick();
    bus.noc_valid_i = 0; #1;
    total_cnt++; if (bus.snk_valid !== 1'b1 || bus.snk_dst_ok !== 1'b0) $display("FAIL dst_ok_foreign: got v=%b ok=%b want 1 0", bus.snk_valid, bus.snk_dst_ok); else pass_cnt++;
    total_cnt++; if (bus.err_misroute !== 1'b1) $display("FAIL dst_misroute_latch: got %b want 1", bus.err_misroute); else pass_cnt++;
    bus.snk_ready = 1; tick();
    bus.snk_ready = 0;
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.src_valid = 1'($urandom_range(0, 1));
      bus.src_dst_dim0 = 2'($urandom); bus.src_dst_dim1 = 2'($urandom); bus.src_payload = 4'($urandom);
      bus.noc_off_i = ($urandom_range(0, 3) == 0);
      bus.noc_valid_i = 1'($urandom_range(0, 1));
      bus.noc_data_i = ($urandom_range(0, 3) != 0) ? {X_W'(CX), Y_W'(CY), 4'($urandom)} : 8'($urandom);
      bus.snk_ready = ($urandom_range(0, 2) != 0);
      #1; model_eval();
      total_cnt++; if (bus.src_ready !== exp_src_ready) $display("FAIL rnd_src_ready_%0d: got %b want %b", c, bus.src_ready, exp_src_ready); else pass_cnt++;
      total_cnt++; if (bus.noc_valid_o !== exp_noc_valid || (exp_noc_valid && bus.noc_data_o !== exp_noc_data)) $display("FAIL rnd_noc_out_%0d: got v=%b d=%h want v=%b d=%h", c, bus.noc_valid_o, bus.noc_data_o, exp_noc_valid, exp_noc_data); else pass_cnt++;
      total_cnt++; if (bus.snk_valid !== exp_snk_valid || (exp_snk_valid && (bus.snk_payload !== exp_payload || bus.snk_dst_ok !== exp_dst_ok))) $display("FAIL rnd_snk_out_%0d: got v=%b p=%h ok=%b want v=%b p=%h ok=%b", c, bus.snk_valid, bus.snk_payload, bus.snk_dst_ok, exp_snk_valid, exp_payload, exp_dst_ok); else pass_cnt++;
      total_cnt++; if (bus.noc_off_o !== m_off) $display("FAIL rnd_noc_off_%0d: got %b want %b", c, bus.noc_off_o, m_off); else pass_cnt++;
      total_cnt++; if (bus.err_overflow !== m_ovf || bus.err_misroute !== m_mis) $display("FAIL rnd_errors_%0d: got ovf=%b mis=%b want ovf=%b mis=%b", c, bus.err_overflow, bus.err_misroute, m_ovf, m_mis); else pass_cnt++;
`ifdef NI_STATS_EN
      total_cnt++; if (bus.stat_inj !== 16'(m_stat_inj) || bus.stat_ej !== 16'(m_stat_ej) || bus.stat_stall !== 16'(m_stat_stall)) $display("FAIL rnd_stats_%0d: got %0d %0d %0d want %0d %0d %0d", c, bus.stat_inj, bus.stat_ej, bus.stat_stall, m_stat_inj, m_stat_ej, m_stat_stall); else pass_cnt++;
`else
      total_cnt++; if ({bus.stat_inj, bus.stat_ej, bus.stat_stall} !== 48'd0) $display("FAIL rnd_stats_tied_%0d: got %h want 0", c, {bus.stat_inj, bus.stat_ej, bus.stat_stall}); else pass_cnt++;
`endif
      tick();
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    bus.noc_off_i = 1; bus.snk_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.src_valid = 1; bus.src_payload = 4'(i + 1);
      bus.noc_valid_i = 1; bus.noc_data_i = {X_W'(CX), Y_W'(CY), 4'(i)};
      tick();
    end
    bus.src_valid = 0; bus.noc_valid_i = 0; bus.noc_off_i = 0;
    #2; rst = 0; #1;
    model_reset();
    total_cnt++; if (bus.noc_valid_o !== 1'b0 || bus.snk_valid !== 1'b0 || bus.src_ready !== 1'b0) $display("FAIL midrst_outputs: got nv=%b sv=%b sr=%b want 0 0 0", bus.noc_valid_o, bus.snk_valid, bus.src_ready); else pass_cnt++;
    total_cnt++; if (bus.noc_off_o !== 1'b0 || bus.err_overflow !== 1'b0 || bus.err_misroute !== 1'b0) $display("FAIL midrst_flags: got off=%b ovf=%b mis=%b want 0 0 0", bus.noc_off_o, bus.err_overflow, bus.err_misroute); else pass_cnt++;
    total_cnt++; if ({bus.stat_inj, bus.stat_ej, bus.stat_stall} !== 48'd0) $display("FAIL midrst_stats: got %h want 0", {bus.stat_inj, bus.stat_ej, bus.stat_stall}); else pass_cnt++;
    @(negedge clk); @(negedge clk); rst = 1; #1;
    total_cnt++; if (bus.src_ready !== 1'b1 || bus.noc_valid_o !== 1'b0 || bus.snk_valid !== 1'b0) $display("FAIL midrst_release: got sr=%b nv=%b sv=%b want 1 0 0", bus.src_ready, bus.noc_valid_o, bus.snk_valid); else pass_cnt++;
  endtask

`ifdef NI_STATS_EN
  task automatic test_stat_saturate();
    bus.noc_off_i = 1; bus.src_valid = 1; bus.src_payload = 4'h5;
    tick();
    bus.src_valid = 0;
    repeat (70000) @(posedge clk);
    @(negedge clk); #1;
    total_cnt++; if (bus.stat_stall !== 16'hFFFF) $display("FAIL stat_stall_saturate: got %h want ffff", bus.stat_stall); else pass_cnt++;
    bus.noc_off_i = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_inject_basic();
    test_inject_stall();
    test_eject_backpressure();
    test_dst_check();
    test_random(400);
    test_reset_mid();
    test_random(200);
`ifdef NI_STATS_EN
    test_stat_saturate();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/noc_network_interface.md
# noc_network_interface

Per-node network interface that sits on the local port of each flattened-butterfly router. It packs client messages (destination coordinates plus payload) into single-flit packets, buffers them, and injects them under the router's off-signal backpressure. On the ejection side it buffers flits arriving from the router, checks the destination, and drives its own off signal back to the router. One instance per node, tiled alongside the NoC top level.

## Interface
- DATA_W, 8, flit width.
- FIFO_DEPTH, 8, entries in each of the inject and eject FIFOs; power of two, ≥4.
- NODE_PER_ROW, 4, nodes in dim0; X_W = max(1, clog2(NODE_PER_ROW)).
- NODE_PER_COL, 4, nodes in dim1; Y_W = max(1, clog2(NODE_PER_COL)).
- CURR_DIM0, 0, this node's dim0 coordinate.
- CURR_DIM1, 0, this node's dim1 coordinate.
- OFF_MARGIN, 2, free-entry threshold for eject backpressure; 1 ≤ OFF_MARGIN < FIFO_DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src_valid  in  1  client message valid.
- src_ready  out  1  inject FIFO can accept.
- src_dst_dim0  in  X_W  destination dim0.
- src_dst_dim1  in  Y_W  destination dim1.
- src_payload  in  PAYLOAD_W  PAYLOAD_W = DATA_W−X_W−Y_W (must be ≥1).
- noc_valid_o  out  1  to router local valid_i.
- noc_data_o  out  DATA_W  to router local data_i.
- noc_off_i  in  1  from router local off_sigs_o; high = do not send.
- noc_valid_i  in  1  from router local valid_o.
- noc_data_i  in  DATA_W  from router local data_o.
- noc_off_o  out  1  to router local off_sigs_i.
- snk_valid  out  1  ejected flit available.
- snk_ready  in  1  client accepts flit.
- snk_payload  out  PAYLOAD_W  ejected payload.
- snk_dst_ok  out  1  head flit's destination equals (CURR_DIM0, CURR_DIM1).
- err_overflow  out  1  sticky: flit arrived while eject FIFO full.
- err_misroute  out  1  sticky: flit ejected with wrong destination.
- stat_inj, stat_ej, stat_stall  out  16 each  statistics counters.

## Operation
- Flit format (bit 0 = MSB): [0 +: X_W] dst_dim0, [X_W +: Y_W] dst_dim1, remainder payload.
- Inject: push on src_valid && src_ready. src_ready = !inj_full && rst high; derived from registered count, so a pop in the same cycle does not raise it.
- noc_valid_o = !inj_empty && !noc_off_i. Every cycle noc_valid_o is high is a transfer; the head pops at that edge. noc_data_o = inj head (combinational from storage).
- Eject: every cycle noc_valid_i is high, noc_data_i is written. If the FIFO is full with no simultaneous pop, the flit is dropped and err_overflow is set.
- Simultaneous write and pop on a full eject FIFO succeeds; count is unchanged.
- snk_valid = !ej_empty; pop on snk_valid && snk_ready. snk_dst_ok is computed from the head entry.
- err_misroute is set at the edge writing a flit whose destination ≠ own coordinates. The flit is still stored and delivered.
- noc_off_o is registered: next value = (FIFO_DEPTH − next_count) ≤ OFF_MARGIN, where next_count includes that cycle's write and pop.
- Sticky errors clear only on reset.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.

## Timing
- Reset (rst low, async): FIFOs empty, pointers 0; outputs noc_valid_o=0, noc_off_o=0, src_ready=0, snk_valid=0, errors=0, stats=0.
- Inject latency: a message accepted at edge N appears on noc_valid_o in cycle N+1 if noc_off_i is low.
- Eject latency: a flit written at edge N gives snk_valid in cycle N+1.
- noc_off_o reacts one cycle after the count update. With OFF_MARGIN=2, a router with one cycle of reaction lag cannot overflow the eject FIFO.
- Reset mid-transfer: in-flight FIFO contents are discarded; no partial state survives.

## Configuration
- NI_STATS_EN defined: stat_inj counts noc transfers, stat_ej counts eject writes (including dropped flits), and stat_stall counts cycles with !inj_empty && noc_off_i. All three are 16-bit, saturating at 16'hFFFF.
- NI_STATS_EN undefined: the stat_* ports remain but are tied to 0, and no counter registers exist.

## Test plan
- Config: DATA_W=8, 4×4 mesh, node (1,2). Push dst(3,0) payload 4'hA with noc_off_i=0 → noc_valid_o high next cycle with noc_data_o=8'hCA, and it pops.
- Hold noc_off_i=1 and push 9 messages → src_ready low after 8, noc_valid_o stays 0, stat_stall increments every cycle. Release off → 8 flits drain in order on consecutive cycles.
- snk_ready=0 and router sends continuously, obeying noc_off_o with 1-cycle lag → noc_off_o rises after the 6th write, exactly 7 flits are stored, err_overflow stays 0.
- Eject flit 8'h60 (dst (1,2)) → snk_dst_ok=1. Eject 8'h00 → snk_dst_ok=0 and err_misroute latches 1.
- Assert rst with both FIFOs partly full → all outputs return to their reset values immediately. After release the FIFOs are empty and src_ready=1.
- With NI_STATS_EN, hold noc_off_i=1 and the inject FIFO nonempty for 70000 cycles → stat_stall saturates at 16'hFFFF.
